cache_ctrl: RTL

//  Write-back, direct-mapped cache controller between the CPU port and the 16-set cache array.

---
 rtl/cache_pkg.sv | 62 ++++++
 rtl/cache_hs.sv | 40 ++++
 rtl/cache_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared constants, address-field helpers and state encodings for the cache controller.
// No logic of its own; imported by cache_hs and cache_ctrl.
// CPU/memory word address layout is {tag, index, word}.
package cache_pkg;

   localparam int TAG_W  = 5;
   localparam int IDX_W  = 4;
   localparam int WORD_W = 2;
   localparam int DATA_W = 16;
   localparam int ADDR_W = TAG_W + IDX_W + WORD_W;

   localparam logic [WORD_W-1:0] W_LAST = {WORD_W{1'b1}};
   localparam logic [WORD_W-1:0] W_ONE  = {{(WORD_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_INIT,
      S_IDLE,
      S_CMP,
      S_WB_RD,
      S_WB_WR,
      S_FILL_RD,
      S_FILL_WR,
      S_RETRY,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_EN,
      HS_WAIT
   } hs_state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return a[WORD_W +: IDX_W];
   endfunction

   function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
      return a[WORD_W-1:0];
   endfunction

   function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0]  t,
                                                  input logic [IDX_W-1:0]  i,
                                                  input logic [WORD_W-1:0] w);
      return {t, i, w};
   endfunction

   // States that run one handshake with the cache array.
   function automatic logic is_cache_state(input state_t s);
      return (s == S_INIT) || (s == S_CMP) || (s == S_WB_RD) ||
             (s == S_FILL_WR) || (s == S_RETRY);
   endfunction

   // States that hold a request towards main memory.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_WB_WR) || (s == S_FILL_RD);
   endfunction

endpackage

// File: rtl/cache_hs.sv
// Four-phase enable/ack sequencer towards the cache array.
// Latency: c_enable rises the cycle after start; done pulses in the cycle c_ack is seen high.
// Backpressure: a new access is only started once c_ack has returned low.
module cache_hs
   import cache_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic c_ack,
   output logic c_enable,
   output logic done
);

   hs_state_t hs_q, hs_d;

   // Handshake phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hs_q <= HS_IDLE;
      else        hs_q <= hs_d;
   end

   // Raise enable on start, drop it on ack, then wait for ack to fall.
   always_comb begin
      hs_d = hs_q;
      case (hs_q)
         HS_IDLE: if (start)  hs_d = HS_EN;
         HS_EN:   if (c_ack)  hs_d = HS_WAIT;
         HS_WAIT: if (!c_ack) hs_d = HS_IDLE;
         default:             hs_d = HS_IDLE;
      endcase
   end

   // Enable is held for the whole request phase; done marks the sample cycle.
   always_comb begin
      c_enable = (hs_q == HS_EN);
      done     = (hs_q == HS_EN) && c_ack;
   end

endmodule

// File: rtl/cache_ctrl.sv
// Write-back direct-mapped cache controller: compare, dirty write-back, 4-word fill, hit/miss stats.
// Latency: hit = compare handshake + 1 cycle; misses add 4 fills (and 4 write-backs when dirty).
// Backpressure: cpu_busy outside IDLE, cpu_req ignored while busy; waits on c_ack and mem_ack.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_busy,
   output logic              c_enable,
   output logic              c_rst,
   output logic              c_comp,
   output logic              c_write,
   output logic              c_valid_in,
   output logic [IDX_W-1:0]  c_index,
   output logic [WORD_W-1:0] c_word,
   output logic [TAG_W-1:0]  c_tag_in,
   output logic [DATA_W-1:0] c_data_in,
   input  logic              c_hit,
   input  logic              c_dirty,
   input  logic              c_valid,
   input  logic              c_ack,
   input  logic [TAG_W-1:0]  c_tag_out,
   input  logic [DATA_W-1:0] c_data_out,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt,
   output logic              err
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
   endfunction

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   buf_q, buf_d;
   logic [WORD_W-1:0]   w_q, w_d;
   logic [TAG_W-1:0]    vtag_q, vtag_d;
   logic [CNT_W-1:0]    hit_d, miss_d;
   logic                err_d;

   logic                cache_start, cache_start_d;
   logic                hs_done;
   logic                mem_done;

   logic                cpu_ready_d, cpu_busy_d;
   logic [DATA_W-1:0]   cpu_rdata_d;
   logic                c_rst_d, c_comp_d, c_write_d, c_valid_in_d;
   logic [IDX_W-1:0]    c_index_d;
   logic [WORD_W-1:0]   c_word_d;
   logic [TAG_W-1:0]    c_tag_in_d;
   logic [DATA_W-1:0]   c_data_in_d;
   logic                mem_req_d, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_d;

   // mem_ack only counts while our request is actually up.
   assign mem_done = mem_req && mem_ack;

   cache_hs u_hs (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (cache_start),
      .c_ack    (c_ack),
      .c_enable (c_enable),
      .done     (hs_done)
   );

   // State, transaction context, statistics and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         buf_q       <= '0;
         w_q         <= '0;
         vtag_q      <= '0;
         hit_cnt     <= '0;
         miss_cnt    <= '0;
         err         <= 1'b0;
         cache_start <= 1'b0;
         cpu_ready   <= 1'b0;
         cpu_busy    <= 1'b0;
         cpu_rdata   <= '0;
         c_rst       <= 1'b0;
         c_comp      <= 1'b0;
         c_write     <= 1'b0;
         c_valid_in  <= 1'b0;
         c_index     <= '0;
         c_word      <= '0;
         c_tag_in    <= '0;
         c_data_in   <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         w_q         <= w_d;
         vtag_q      <= vtag_d;
         hit_cnt     <= hit_d;
         miss_cnt    <= miss_d;
         err         <= err_d;
         cache_start <= cache_start_d;
         cpu_ready   <= cpu_ready_d;
         cpu_busy    <= cpu_busy_d;
         cpu_rdata   <= cpu_rdata_d;
         c_rst       <= c_rst_d;
         c_comp      <= c_comp_d;
         c_write     <= c_write_d;
         c_valid_in  <= c_valid_in_d;
         c_index     <= c_index_d;
         c_word      <= c_word_d;
         c_tag_in    <= c_tag_in_d;
         c_data_in   <= c_data_in_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
      end
   end

   // Next state plus context/statistic updates; advances on handshake completion.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      buf_d   = buf_q;
      w_d     = w_q;
      vtag_d  = vtag_q;
      hit_d   = hit_cnt;
      miss_d  = miss_cnt;
      err_d   = err;
      case (state_q)
         S_INIT: if (hs_done) state_d = S_IDLE;
         S_IDLE: if (cpu_req) begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            state_d = S_CMP;
         end
         S_CMP: if (hs_done) begin
            buf_d = c_data_out;
            w_d   = '0;
            if (c_hit) begin
               hit_d   = sat_inc(hit_cnt);
               state_d = S_DONE;
            end else begin
               miss_d = sat_inc(miss_cnt);
               if (c_valid && c_dirty) begin
                  vtag_d  = c_tag_out;
                  state_d = S_WB_RD;
               end else begin
                  state_d = S_FILL_RD;
               end
            end
         end
         S_WB_RD: if (hs_done) begin
            buf_d   = c_data_out;
            state_d = S_WB_WR;
         end
         S_WB_WR: if (mem_done) begin
            if (w_q == W_LAST) begin
               w_d     = '0;
               state_d = S_FILL_RD;
            end else begin
               w_d     = w_q + W_ONE;
               state_d = S_WB_RD;
            end
         end
         S_FILL_RD: if (mem_done) begin
            buf_d   = mem_rdata;
            state_d = S_FILL_WR;
         end
         S_FILL_WR: if (hs_done) begin
            if (w_q == W_LAST) begin
               state_d = S_RETRY;
            end else begin
               w_d     = w_q + W_ONE;
               state_d = S_FILL_RD;
            end
         end
         S_RETRY: if (hs_done) begin
            buf_d = c_data_out;
            if (!c_hit) err_d = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

   // Outputs for the coming state, so c_* and mem_* settle together with the state.
   always_comb begin
      cpu_busy_d    = (state_d != S_IDLE);
      cpu_ready_d   = (state_d == S_DONE);
      cpu_rdata_d   = (state_d == S_DONE && !we_d) ? buf_d : '0;
      cache_start_d = is_cache_state(state_d);
      c_rst_d       = 1'b0;
      c_comp_d      = 1'b0;
      c_write_d     = 1'b0;
      c_valid_in_d  = 1'b0;
      c_index_d     = '0;
      c_word_d      = '0;
      c_tag_in_d    = '0;
      c_data_in_d   = '0;
      // A request just acknowledged always drops for one cycle, even when
      // write-back hands straight over to the first fill read.
      mem_req_d     = is_mem_state(state_d) && !mem_done;
      mem_we_d      = 1'b0;
      mem_addr_d    = '0;
      mem_wdata_d   = '0;
      case (state_d)
         S_INIT: c_rst_d = 1'b1;
         S_CMP, S_RETRY: begin
            c_comp_d    = 1'b1;
            c_write_d   = we_d;
            c_index_d   = addr_idx(addr_d);
            c_word_d    = addr_word(addr_d);
            c_tag_in_d  = addr_tag(addr_d);
            c_data_in_d = wdata_d;
         end
         S_WB_RD: begin
            c_index_d = addr_idx(addr_d);
            c_word_d  = w_d;
         end
         S_FILL_WR: begin
            c_write_d    = 1'b1;
            c_valid_in_d = 1'b1;
            c_index_d    = addr_idx(addr_d);
            c_word_d     = w_d;
            c_tag_in_d   = addr_tag(addr_d);
            c_data_in_d  = buf_d;
         end
         S_WB_WR: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = mk_addr(vtag_d, addr_idx(addr_d), w_d);
            mem_wdata_d = buf_d;
         end
         S_FILL_RD: begin
            mem_addr_d = mk_addr(addr_tag(addr_d), addr_idx(addr_d), w_d);
         end
         default: ;
      endcase
   end

endmodule
